// File: rtl/relu_drain.sv
// relu_drain: captures a packed vector of signed node sums, applies
// ReLU + arithmetic right shift + unsigned saturation, streams one node per
// valid/ready transfer, and reports the argmax of the drained vector.
module relu_drain #(
    parameter int NODES = 2,
    parameter int SUM_W = 5,
    parameter int OUT_W = 4,
    parameter int SHIFT = 0,
    parameter int IDX_W = 1
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [NODES*SUM_W-1:0] sumIn,
    input  logic                   load,
    output logic                   busy,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [OUT_W-1:0]       outData,
    output logic [IDX_W-1:0]       outIndex,
    output logic                   outLast,
    output logic [IDX_W-1:0]       maxIndex,
    output logic                   maxValid
);

    typedef enum logic {IDLE, DRAIN} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NODES - 1);
    localparam logic [31:0]      OUT_MAX  = (32'd1 << OUT_W) - 32'd1;

    state_t           state;
    state_t           state_nxt;
    logic [SUM_W-1:0] bank [NODES];
    logic [IDX_W-1:0] index;
    logic [OUT_W-1:0] run_max;
    logic [IDX_W-1:0] run_idx;
    logic [OUT_W-1:0] act_cur;
    logic             is_last;
    logic             xfer;
    logic             accept;
    logic             new_max;

    // Negative sums clamp to zero; non-negative sums are shifted and then
    // saturated to the largest unsigned OUT_W value.
    function automatic logic [OUT_W-1:0] activate(input logic [SUM_W-1:0] v);
        logic [31:0] s;
        if (v[SUM_W-1]) begin
            return '0;
        end
        s = 32'(v) >> SHIFT;
        if (s > OUT_MAX) begin
            return OUT_MAX[OUT_W-1:0];
        end
        return s[OUT_W-1:0];
    endfunction

    // Handshake decode: a load is honoured when idle, or on the final
    // transfer so a new vector can follow back-to-back.
    always_comb begin
        act_cur = activate(bank[index]);
        is_last = (index == LAST_IDX);
        xfer    = (state == DRAIN) && outReady;
        accept  = load && ((state == IDLE) || (xfer && is_last));
        new_max = (act_cur > run_max);
    end

    // State register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (accept) begin
                    state_nxt = DRAIN;
                end else if (xfer && is_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bank capture, stream index and running argmax tracking.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NODES; i++) begin
                bank[i] <= '0;
            end
            index    <= '0;
            run_max  <= '0;
            run_idx  <= '0;
            maxIndex <= '0;
            maxValid <= 1'b0;
        end else begin
            // The final node takes part in the argmax, so compare it here
            // rather than reading the running value one cycle late.
            if (xfer && is_last) begin
                maxIndex <= new_max ? index : run_idx;
                maxValid <= 1'b1;
            end
            if (accept) begin
                for (int i = 0; i < NODES; i++) begin
                    bank[i] <= sumIn[i*SUM_W +: SUM_W];
                end
                index    <= '0;
                run_max  <= '0;
                run_idx  <= '0;
                maxValid <= 1'b0;
            end else if (xfer) begin
                if (new_max) begin
                    run_max <= act_cur;
                    run_idx <= index;
                end
                index <= is_last ? '0 : index + 1'b1;
            end
        end
    end

    // Stream outputs depend only on registered state, never on outReady.
    always_comb begin
        busy     = (state == DRAIN);
        outValid = busy;
        outData  = busy ? act_cur : '0;
        outIndex = busy ? index : '0;
        outLast  = busy && is_last;
    end

endmodule

// File: tb/tb_relu_drain.sv
// tb_relu_drain: directed and randomized checks of relu_drain using three
// parameterizations driven by the same stimulus and a behavioural model.
module tb_relu_drain;

    localparam int NODES = 2;
    localparam int SUM_W = 5;
    localparam int OW [3] = '{4, 3, 4};
    localparam int SH [3] = '{0, 0, 1};

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [9:0] sum_in = '0;
    logic       load = 1'b0;
    logic       out_ready = 1'b0;

    logic       busy0, busy1, busy2;
    logic       vld0, vld1, vld2;
    logic       last0, last1, last2;
    logic       mv0, mv1, mv2;
    logic [3:0] data0;
    logic [2:0] data1;
    logic [3:0] data2;
    logic       idx0, idx1, idx2;
    logic       mi0, mi1, mi2;

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model state
    bit m_busy = 0;
    int m_idx = 0;
    int m_bank [NODES] = '{0, 0};
    int m_maxi [3] = '{0, 0, 0};
    bit m_mv = 0;

    always #5 clk = ~clk;

    relu_drain #(.NODES(2), .SUM_W(5), .OUT_W(4), .SHIFT(0), .IDX_W(1)) u_dut (
        .clk(clk), .clr(clr), .sumIn(sum_in), .load(load), .busy(busy0),
        .outValid(vld0), .outReady(out_ready), .outData(data0), .outIndex(idx0),
        .outLast(last0), .maxIndex(mi0), .maxValid(mv0));

    relu_drain #(.NODES(2), .SUM_W(5), .OUT_W(3), .SHIFT(0), .IDX_W(1)) u_sat (
        .clk(clk), .clr(clr), .sumIn(sum_in), .load(load), .busy(busy1),
        .outValid(vld1), .outReady(out_ready), .outData(data1), .outIndex(idx1),
        .outLast(last1), .maxIndex(mi1), .maxValid(mv1));

    relu_drain #(.NODES(2), .SUM_W(5), .OUT_W(4), .SHIFT(1), .IDX_W(1)) u_shf (
        .clk(clk), .clr(clr), .sumIn(sum_in), .load(load), .busy(busy2),
        .outValid(vld2), .outReady(out_ready), .outData(data2), .outIndex(idx2),
        .outLast(last2), .maxIndex(mi2), .maxValid(mv2));

    function automatic int act(input int raw, input int ow, input int sh);
        int s;
        int mx;
        if (raw >= (1 << (SUM_W - 1))) return 0;
        s  = raw >> sh;
        mx = (1 << ow) - 1;
        return (s > mx) ? mx : s;
    endfunction

    function automatic int argmax(input int k);
        int best;
        int bi;
        best = -1;
        bi   = 0;
        for (int i = 0; i < NODES; i++) begin
            if (act(m_bank[i], OW[k], SH[k]) > best) begin
                best = act(m_bank[i], OW[k], SH[k]);
                bi   = i;
            end
        end
        return bi;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Compare every cycle at the falling edge, then advance the model with
    // the inputs the next rising edge will sample.
    initial forever begin
        bit xfer;
        bit lst;
        bit acc;
        @(negedge clk);
        if (clr) begin
            m_busy = 0; m_idx = 0; m_mv = 0;
            for (int i = 0; i < NODES; i++) m_bank[i] = 0;
            for (int k = 0; k < 3; k++) m_maxi[k] = 0;
        end
        check("busy0", busy0, m_busy);
        check("busy1", busy1, m_busy);
        check("busy2", busy2, m_busy);
        check("valid0", vld0, m_busy);
        check("valid1", vld1, m_busy);
        check("valid2", vld2, m_busy);
        check("maxvalid0", mv0, m_mv);
        check("maxvalid1", mv1, m_mv);
        check("maxvalid2", mv2, m_mv);
        check("maxindex0", mi0, m_maxi[0]);
        check("maxindex1", mi1, m_maxi[1]);
        check("maxindex2", mi2, m_maxi[2]);
        if (m_busy) begin
            check("data0", data0, act(m_bank[m_idx], OW[0], SH[0]));
            check("data1", data1, act(m_bank[m_idx], OW[1], SH[1]));
            check("data2", data2, act(m_bank[m_idx], OW[2], SH[2]));
            check("index0", idx0, m_idx);
            check("index1", idx1, m_idx);
            check("last0", last0, m_idx == NODES - 1);
            check("last2", last2, m_idx == NODES - 1);
        end
        if (!clr) begin
            xfer = m_busy && out_ready;
            lst  = (m_idx == NODES - 1);
            acc  = load && (!m_busy || (xfer && lst));
            if (xfer && lst) begin
                for (int k = 0; k < 3; k++) m_maxi[k] = argmax(k);
                m_mv = 1;
            end
            if (acc) begin
                for (int i = 0; i < NODES; i++) m_bank[i] = int'(sum_in[i*SUM_W +: SUM_W]);
                m_idx  = 0;
                m_busy = 1;
                m_mv   = 0;
            end else if (xfer) begin
                if (lst) begin
                    m_busy = 0;
                    m_idx  = 0;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    initial begin
        // reset state
        tick; tick;
        check("rst_busy", busy0, 0);
        check("rst_valid", vld0, 0);
        check("rst_data", data0, 0);
        check("rst_index", idx0, 0);
        check("rst_last", last0, 0);
        check("rst_maxindex", mi0, 0);
        check("rst_maxvalid", mv0, 0);
        clr = 1'b0;
        tick;

        // basic drain
        sum_in = {5'b11111, 5'b01010}; load = 1'b1; out_ready = 1'b1;
        tick; load = 1'b0;
        check("basic_d0", data0, 10);
        check("basic_i0", idx0, 0);
        check("basic_sat_d0", data1, 7);
        check("basic_shf_d0", data2, 5);
        tick;
        check("basic_d1", data0, 0);
        check("basic_i1", idx0, 1);
        check("basic_last", last0, 1);
        tick;
        check("basic_busy", busy0, 0);
        check("basic_maxindex", mi0, 0);
        check("basic_maxvalid", mv0, 1);

        // saturation / shift / negative
        sum_in = {5'b10000, 5'b01011}; load = 1'b1;
        tick; load = 1'b0;
        check("sat_default", data0, 11);
        check("sat_outw3", data1, 7);
        check("sat_shift1", data2, 5);
        tick;
        check("neg_default", data0, 0);
        check("neg_shift1", data2, 0);
        tick;

        // backpressure
        sum_in = {5'd9, 5'd3}; load = 1'b1; out_ready = 1'b0;
        tick; load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_d", data0, 3);
            check("bp_hold_i", idx0, 0);
            tick;
        end
        out_ready = 1'b1;
        check("bp_rel_d0", data0, 3);
        tick;
        check("bp_rel_d1", data0, 9);
        check("bp_rel_i1", idx0, 1);
        tick;
        check("bp_maxindex", mi0, 1);

        // tie and ignored load
        sum_in = {5'd6, 5'd6}; load = 1'b1;
        tick; load = 1'b1; sum_in = {5'd1, 5'd2};
        tick; load = 1'b0;
        check("tie_d1", data0, 6);
        check("tie_i1", idx0, 1);
        tick;
        check("tie_maxindex", mi0, 0);
        check("tie_maxvalid", mv0, 1);

        // back-to-back
        sum_in = {5'd7, 5'd2}; load = 1'b1;
        tick; load = 1'b0;
        tick;
        load = 1'b1; sum_in = {5'd1, 5'd12};
        tick; load = 1'b0;
        check("b2b_i0", idx0, 0);
        check("b2b_d0", data0, 12);
        check("b2b_busy", busy0, 1);
        check("b2b_maxvalid", mv0, 0);
        check("b2b_maxindex", mi0, 1);
        tick; tick;

        // reset mid-drain
        sum_in = {5'd5, 5'd4}; load = 1'b1;
        tick; load = 1'b0;
        clr = 1'b1;
        #1;
        check("clr_valid", vld0, 0);
        check("clr_busy", busy0, 0);
        check("clr_data", data0, 0);
        check("clr_maxvalid", mv0, 0);
        tick; clr = 1'b0;
        tick; tick;
        check("clr_idle", busy0, 0);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            sum_in    = 10'($urandom);
            load      = ($urandom_range(0, 9) < 3);
            out_ready = ($urandom_range(0, 9) < 7);
            clr       = ($urandom_range(0, 99) < 2);
            tick;
        end
        clr = 1'b0; load = 1'b0; out_ready = 1'b1;
        tick; tick; tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
